i2c_tx_sched: RTL and testbench
===============================

Name: i2c_tx_sched

Overview:
- Packet-level TX scheduler feeding the I2C slave PHY's read-return path (empty/pop/din).
- Shares the PHY between two requesters: 0 = status reports, 1 = nonce/data reports. Arbitration is round-robin at packet boundaries; packets never interleave.
- Buffers words in a 2-entry tagged FIFO, so the PHY sees a continuous word stream.
- Flushes the remainder of a packet when the PHY reports a read error.

Parameters:
- DW, 32, word width; matches PHY din.
- CNT_W, 16, width of per-requester completed-packet counters.
- TIMEOUT, 1024, starvation timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reg_rst  in  1  synchronous soft clear; same effect as rst
- req0_valid  in  1  requester 0 word valid
- req0_data  in  DW  requester 0 word
- req0_last  in  1  final word of requester 0 packet
- req0_ready  out  1  requester 0 word accepted when valid&ready
- req1_valid, req1_data, req1_last, req1_ready  same as requester 0, for requester 1
- phy_empty  out  1  high when FIFO holds no word
- phy_pop  in  1  PHY consumes head word this cycle
- phy_din  out  DW  head word; stable while phy_empty=0 and no pop
- phy_rerr  in  1  PHY read-error pulse
- pkt_done  out  1  pulse: last word of a packet popped by PHY
- pkt_done_id  out  1  requester of that packet; valid with pkt_done
- pkt_abort  out  1  pulse: current packet aborted
- done_cnt0  out  CNT_W  completed packets, requester 0
- done_cnt1  out  CNT_W  completed packets, requester 1

Behaviour:
- Reset values (rst or reg_rst):
  - state IDLE; FIFO empty; phy_empty=1; phy_din=0
  - req*_ready=0; pkt_done=0; pkt_abort=0; pkt_done_id=0
  - prio=0 (requester 0 favoured); counters 0
- FIFO: 2 entries of {last, data}; phy_din = head data.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - phy_pop while empty: ignored; no state change.
  - Clear: count set to 0 in the cycle it is asserted; overrides push and pop.
- State IDLE:
  - All ready=0.
  - If any req_valid: grant <= the favoured requester if valid, else the other; next state SEND.
  - One-cycle arbitration latency.
- State SEND:
  - ready[grant] = (count<2) | phy_pop; the other requester's ready=0.
  - Accepted word is pushed into the FIFO.
  - Accepted word with last=1: next state IDLE, prio <= ~grant.
  - phy_rerr: FIFO clear, pkt_abort pulse next cycle, next state FLUSH.
  - If that same cycle also accepts a last word: next state IDLE instead; the word is dropped; prio <= ~grant.
- State FLUSH:
  - ready[grant]=1; accepted words are discarded.
  - Accepted word with last=1: next state IDLE, prio <= ~grant.
- phy_rerr in IDLE: FIFO clear; no abort pulse.
- Completion, registered (1-cycle latency):
  - phy_pop on a head entry with last=1 -> pkt_done=1, pkt_done_id = the owning requester, done_cnt[id] increments.
  - Counters wrap modulo 2^CNT_W.
  - The owning requester's id is stored per entry, so completion is attributed correctly after a grant change.
- Ready depends combinationally only on state, grant, count and phy_pop; there is no path from valid to ready.

Optional Feature:
- Macro: I2C_TX_SCHED_TIMEOUT_EN.
- Defined:
  - In SEND, a counter increments each cycle that the granted req_valid=0 and the FIFO is empty; it resets on any accept.
  - Reaching TIMEOUT: pkt_abort pulse, next state FLUSH. The FIFO is already empty.
- Undefined: no counter; SEND waits indefinitely for the granted requester.

Decomposition:
- Package i2c_tx_sched_pkg holds:
  - state encoding localparams IDLE=2'd0, SEND=2'd1, FLUSH=2'd2
  - FIFO_DEPTH=2
  - typedef of the FIFO entry {id, last, data}
- Sub-module i2c_tx_fifo2: 2-entry FIFO with push, pop, clr, count, head outputs.
- Arbitration FSM and counters stay in i2c_tx_sched.

Test Plan:
- Single packet: req0 sends 3 words A0..A2 (last on A2); PHY pops one word every 10 cycles.
  - Expect phy_din sequence A0, A1, A2.
  - Expect pkt_done with id=0 one cycle after the pop of A2; done_cnt0=1.
- Contention: req0 and req1 both valid from reset, 2-word packets each, repeated 4 times.
  - Expect grant order 0,1,0,1,...; no interleaving.
  - Expect done_cnt0=4 and done_cnt1=4.
- Read error: phy_rerr after the first pop of a 4-word req1 packet.
  - Expect phy_empty=1 the next cycle and pkt_abort pulse.
  - Expect the remaining words acked and dropped; next packet is granted to req0.
- Back-to-back: phy_pop every cycle.
  - Expect FIFO never empty between words of a packet once filled.
  - Expect a simultaneous push/pop to keep count at 1.
- reg_rst mid-packet with 2 words buffered.
  - Expect phy_empty=1, counters 0, state IDLE the next cycle.
- With I2C_TX_SCHED_TIMEOUT_EN and TIMEOUT=8: req0 stalls after its first word is popped.
  - Expect pkt_abort 8 cycles after the FIFO empties, then FLUSH.

Source files
------------

// File: rtl/i2c_tx_sched_pkg.sv
// Shared types and constants for the I2C TX packet scheduler.
package i2c_tx_sched_pkg;

  // Scheduler state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;

  // Per-entry tag stored beside each FIFO data word. The data field is kept
  // separate so its width can follow the DW parameter of the instantiating module.
  typedef struct packed {
    logic id;    // owning requester
    logic last;  // final word of its packet
  } fifo_tag_t;

endpackage

// File: rtl/i2c_tx_fifo2.sv
// Two-entry tagged FIFO between the scheduler and the PHY read-return path.
// Push and pop may coincide (also when full); clr empties it and wins over both.
module i2c_tx_fifo2
  import i2c_tx_sched_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fifo_tag_t     push_tag,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          clr,
  output logic [1:0]    count,
  output logic          empty,
  output fifo_tag_t     head_tag,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] data_q [FIFO_DEPTH];
  fifo_tag_t     tag_q  [FIFO_DEPTH];
  logic          rd_q;
  logic [1:0]    cnt_q;

  logic pop_eff;
  logic push_eff;
  logic wr_idx;

  // Effective push/pop and write slot; a full FIFO with a pop writes the slot being freed
  always_comb begin
    pop_eff  = pop & (cnt_q != 2'd0);
    push_eff = push & ~clr & ((cnt_q != 2'(FIFO_DEPTH)) | pop_eff);
    wr_idx   = rd_q ^ cnt_q[0];
  end

  // Storage, read pointer and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_eff) begin
        data_q[wr_idx] <= push_data;
        tag_q[wr_idx]  <= push_tag;
      end
      if (clr) begin
        rd_q  <= 1'b0;
        cnt_q <= 2'd0;
      end else begin
        if (pop_eff) rd_q <= ~rd_q;
        cnt_q <= cnt_q + 2'(push_eff) - 2'(pop_eff);
      end
    end
  end

  // Head view; data reads as zero while empty
  always_comb begin
    count     = cnt_q;
    empty     = (cnt_q == 2'd0);
    head_tag  = tag_q[rd_q];
    head_data = empty ? '0 : data_q[rd_q];
  end

endmodule

// File: rtl/i2c_tx_sched.sv
// Packet-level TX scheduler sharing the I2C slave PHY read-return path between
// a status requester (0) and a nonce/data requester (1). Round-robin at packet
// boundaries, packets never interleave, and a PHY read error flushes the rest
// of the current packet.
// Optional build macro I2C_TX_SCHED_TIMEOUT_EN adds a starvation timeout in SEND.
module i2c_tx_sched
  import i2c_tx_sched_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_rst,
  input  logic             req0_valid,
  input  logic [DW-1:0]    req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [DW-1:0]    req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             phy_empty,
  input  logic             phy_pop,
  output logic [DW-1:0]    phy_din,
  input  logic             phy_rerr,
  output logic             pkt_done,
  output logic             pkt_done_id,
  output logic             pkt_abort,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   prio_q, prio_d;
  logic   abort_q, abort_d;
  logic   done_q, done_d;
  logic   done_id_q, done_id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic [1:0]    fifo_count;
  logic          fifo_empty;
  fifo_tag_t     head_tag;
  logic [DW-1:0] head_data;
  logic          fifo_push;
  logic          fifo_clr;

  logic          rdy;
  logic          acc;
  logic          g_valid;
  logic          g_last;
  logic [DW-1:0] g_data;
  logic          pop_eff;
  logic          tmo_hit;

  // Granted requester's word and the ready handshake; no path from valid to ready
  always_comb begin
    unique case (state_q)
      SEND:    rdy = (fifo_count < 2'(FIFO_DEPTH)) | phy_pop;
      FLUSH:   rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
    req0_ready = rdy & ~grant_q;
    req1_ready = rdy & grant_q;
    g_valid    = grant_q ? req1_valid : req0_valid;
    g_last     = grant_q ? req1_last  : req0_last;
    g_data     = grant_q ? req1_data  : req0_data;
    acc        = rdy & g_valid;
    pop_eff    = phy_pop & ~fifo_empty;
    fifo_clr   = reg_rst | phy_rerr;
  end

`ifdef I2C_TX_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Starvation counter: runs while the granted requester is idle and the FIFO has drained
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (reg_rst || state_q != SEND || acc) begin
      tmo_d = '0;
    end else if (!g_valid && fifo_empty) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        tmo_hit = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Arbitration FSM next state; reg_rst forces the reset values
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    abort_d   = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          grant_d = (prio_q ? req1_valid : req0_valid) ? prio_q : ~prio_q;
          state_d = SEND;
        end
      end
      SEND: begin
        fifo_push = acc;
        if (acc && g_last) begin
          // A last word arriving with a read error still closes the packet; it is dropped
          state_d = IDLE;
          prio_d  = ~grant_q;
          abort_d = phy_rerr;
        end else if (phy_rerr || tmo_hit) begin
          state_d = FLUSH;
          abort_d = 1'b1;
        end
      end
      FLUSH: begin
        if (acc && g_last) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reg_rst) begin
      state_d = IDLE;
      grant_d = 1'b0;
      prio_d  = 1'b0;
      abort_d = 1'b0;
    end
  end

  // Completion detection and per-requester counters, attributed by the entry's stored id
  always_comb begin
    done_d    = pop_eff & head_tag.last;
    done_id_d = done_d ? head_tag.id : done_id_q;
    cnt0_d    = cnt0_q + CNT_W'(done_d & ~head_tag.id);
    cnt1_d    = cnt1_q + CNT_W'(done_d & head_tag.id);
    if (reg_rst) begin
      done_d    = 1'b0;
      done_id_d = 1'b0;
      cnt0_d    = '0;
      cnt1_d    = '0;
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  i2c_tx_fifo2 #(
    .DW (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_tag  ('{id: grant_q, last: g_last}),
    .push_data (g_data),
    .pop       (phy_pop),
    .clr       (fifo_clr),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head_tag  (head_tag),
    .head_data (head_data)
  );

  assign phy_empty   = fifo_empty;
  assign phy_din     = head_data;
  assign pkt_done    = done_q;
  assign pkt_done_id = done_id_q;
  assign pkt_abort   = abort_q;
  assign done_cnt0   = cnt0_q;
  assign done_cnt1   = cnt1_q;

endmodule

// File: tb/tb_i2c_tx_sched.sv
// Directed bench for i2c_tx_sched: a table of single-packet vectors plus
// hand-written sequences for contention, read error, soft clear and starvation.
module tb_i2c_tx_sched;

  localparam int unsigned DW      = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             reg_rst;
  logic             req0_valid, req0_last, req0_ready;
  logic [DW-1:0]    req0_data;
  logic             req1_valid, req1_last, req1_ready;
  logic [DW-1:0]    req1_data;
  logic             phy_empty, phy_pop, phy_rerr;
  logic [DW-1:0]    phy_din;
  logic             pkt_done, pkt_done_id, pkt_abort;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;

  always #5 clk = ~clk;

  i2c_tx_sched #(
    .DW      (DW),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_rst     (reg_rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .phy_empty   (phy_empty),
    .phy_pop     (phy_pop),
    .phy_din     (phy_din),
    .phy_rerr    (phy_rerr),
    .pkt_done    (pkt_done),
    .pkt_done_id (pkt_done_id),
    .pkt_abort   (pkt_abort),
    .done_cnt0   (done_cnt0),
    .done_cnt1   (done_cnt1)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    logic          id;
    int unsigned   nwords;
    logic [DW-1:0] base;
    int unsigned   period;
    int unsigned   exp_cnt0;
    int unsigned   exp_cnt1;
  } pkt_vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  word_t         q0[$];
  word_t         q1[$];
  logic [DW-1:0] pop_log[$];
  int            pop_cyc[$];
  logic          done_log[$];
  int            done_cyc[$];
  int            abort_cnt = 0;
  int            abort_cyc = 0;
  int unsigned   pop_period = 1;
  int unsigned   pop_wait   = 0;
  logic          pop_en     = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_req();
    req0_valid = (q0.size() != 0);
    req0_data  = (q0.size() != 0) ? q0[0].data : '0;
    req0_last  = (q0.size() != 0) ? q0[0].last : 1'b0;
    req1_valid = (q1.size() != 0);
    req1_data  = (q1.size() != 0) ? q1[0].data : '0;
    req1_last  = (q1.size() != 0) ? q1[0].last : 1'b0;
  endtask

  task automatic drive_pop();
    if (pop_en && !phy_empty && pop_wait == 0) begin
      phy_pop  = 1'b1;
      pop_wait = pop_period - 1;
    end else begin
      phy_pop = 1'b0;
      if (pop_wait > 0) pop_wait--;
    end
  endtask

  // One clock: observe at the falling edge, update and drive 1 time unit after the rising edge
  task automatic tick();
    logic a0, a1;
    @(negedge clk);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    if (phy_pop && !phy_empty) begin
      pop_log.push_back(phy_din);
      pop_cyc.push_back(cyc);
    end
    if (pkt_done) begin
      done_log.push_back(pkt_done_id);
      done_cyc.push_back(cyc);
    end
    if (pkt_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive_req();
    drive_pop();
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
    done_log.delete();
    done_cyc.delete();
    abort_cnt = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    reg_rst  = 1'b0;
    phy_rerr = 1'b0;
    phy_pop  = 1'b0;
    pop_wait = 0;
    pop_en   = 1'b1;
    q0.delete();
    q1.delete();
    drive_req();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic load(input logic id, input logic [DW-1:0] base, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      if (id) q1.push_back('{data: base + DW'(i), last: (i == int'(n) - 1)});
      else    q0.push_back('{data: base + DW'(i), last: (i == int'(n) - 1)});
    end
  endtask

  task automatic run_until_done(input int need, input int budget);
    for (int k = 0; k < budget && done_log.size() < need; k++) tick();
    check("done_events", 64'(done_log.size()), 64'(need));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_vec_t      vecs[6];
    logic [DW-1:0] exp_w;

    vecs[0] = '{1'b0, 3, 32'hA000_0000, 10, 1, 0};
    vecs[1] = '{1'b1, 4, 32'hB000_0000, 1,  1, 1};
    vecs[2] = '{1'b0, 1, 32'hC000_0000, 1,  2, 1};
    vecs[3] = '{1'b1, 2, 32'hC100_0000, 3,  2, 2};
    vecs[4] = '{1'b1, 1, 32'hC200_0000, 2,  2, 3};
    vecs[5] = '{1'b0, 5, 32'hC300_0000, 1,  3, 3};

    // Reset state
    do_reset();
    check("rst_phy_empty", 64'(phy_empty), 64'd1);
    check("rst_phy_din", 64'(phy_din), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_ready1", 64'(req1_ready), 64'd0);
    check("rst_pkt_done", 64'(pkt_done), 64'd0);
    check("rst_pkt_abort", 64'(pkt_abort), 64'd0);
    check("rst_done_id", 64'(pkt_done_id), 64'd0);
    check("rst_cnt0", 64'(done_cnt0), 64'd0);
    check("rst_cnt1", 64'(done_cnt1), 64'd0);
    // Valid alone never raises ready in IDLE
    load(1'b0, 32'h1234_5678, 1);
    drive_req();
    #1;
    check("idle_ready0", 64'(req0_ready), 64'd0);
    q0.delete();
    drive_req();

    // Table of single packets; counters accumulate across vectors
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      pop_period = vecs[v].period;
      pop_wait   = 0;
      load(vecs[v].id, vecs[v].base, vecs[v].nwords);
      drive_req();
      run_until_done(1, 400);
      check($sformatf("v%0d_npop", v), 64'(pop_log.size()), 64'(vecs[v].nwords));
      for (int i = 0; i < pop_log.size() && i < int'(vecs[v].nwords); i++) begin
        exp_w = vecs[v].base + DW'(i);
        check($sformatf("v%0d_word%0d", v, i), 64'(pop_log[i]), 64'(exp_w));
      end
      if (done_log.size() >= 1 && pop_cyc.size() == int'(vecs[v].nwords)) begin
        check($sformatf("v%0d_done_id", v), 64'(done_log[0]), 64'(vecs[v].id));
        check($sformatf("v%0d_done_lat", v), 64'(done_cyc[0] - pop_cyc[vecs[v].nwords - 1]),
              64'd1);
        check($sformatf("v%0d_pop_span", v), 64'(pop_cyc[vecs[v].nwords - 1] - pop_cyc[0]),
              64'((vecs[v].nwords - 1) * vecs[v].period));
      end
      check($sformatf("v%0d_cnt0", v), 64'(done_cnt0), 64'(vecs[v].exp_cnt0));
      check($sformatf("v%0d_cnt1", v), 64'(done_cnt1), 64'(vecs[v].exp_cnt1));
    end

    // Contention: both requesters valid from reset, four 2-word packets each
    do_reset();
    pop_period = 1;
    for (int k = 0; k < 4; k++) begin
      load(1'b0, 32'hD000_0000 + DW'(k << 8), 2);
      load(1'b1, 32'hE000_0000 + DW'(k << 8), 2);
    end
    drive_req();
    run_until_done(8, 400);
    for (int e = 0; e < done_log.size() && e < 8; e++)
      check($sformatf("rr_done%0d", e), 64'(done_log[e]), 64'(e % 2));
    check("rr_npop", 64'(pop_log.size()), 64'd16);
    for (int e = 0; e < pop_log.size() && e < 16; e++) begin
      exp_w = ((e / 2) % 2 == 0) ? 32'hD000_0000 : 32'hE000_0000;
      exp_w = exp_w + DW'((e / 4) << 8) + DW'(e % 2);
      check($sformatf("rr_word%0d", e), 64'(pop_log[e]), 64'(exp_w));
    end
    check("rr_cnt0", 64'(done_cnt0), 64'd4);
    check("rr_cnt1", 64'(done_cnt1), 64'd4);

    // Read error after the first pop of a 4-word req1 packet
    do_reset();
    pop_period = 4;
    load(1'b1, 32'hF000_0000, 4);
    drive_req();
    for (int k = 0; k < 50 && pop_log.size() < 1; k++) tick();
    check("rerr_first_pop", 64'(pop_log.size()), 64'd1);
    load(1'b0, 32'h4400_0000, 1);
    load(1'b1, 32'h6600_0000, 1);
    drive_req();
    phy_rerr = 1'b1;
    tick();
    phy_rerr = 1'b0;
    check("rerr_empty", 64'(phy_empty), 64'd1);
    check("rerr_abort", 64'(pkt_abort), 64'd1);
    tick();
    check("rerr_abort_pulse", 64'(pkt_abort), 64'd0);
    check("rerr_q1_left", 64'(q1.size()), 64'd1);
    if (q1.size() == 1) check("rerr_q1_head", 64'(q1[0].data), 64'h6600_0000);
    pop_period = 1;
    run_until_done(2, 100);
    check("rerr_npop", 64'(pop_log.size()), 64'd3);
    if (pop_log.size() == 3) begin
      check("rerr_pop0", 64'(pop_log[0]), 64'hF000_0000);
      check("rerr_pop1", 64'(pop_log[1]), 64'h4400_0000);
      check("rerr_pop2", 64'(pop_log[2]), 64'h6600_0000);
    end
    if (done_log.size() == 2) begin
      check("rerr_next_grant", 64'(done_log[0]), 64'd0);
      check("rerr_then_req1", 64'(done_log[1]), 64'd1);
    end
    check("rerr_cnt0", 64'(done_cnt0), 64'd1);
    check("rerr_cnt1", 64'(done_cnt1), 64'd1);
    // Read error while idle clears the FIFO but does not abort
    phy_rerr = 1'b1;
    tick();
    phy_rerr = 1'b0;
    check("idle_rerr_abort", 64'(pkt_abort), 64'd0);
    check("rerr_abort_total", 64'(abort_cnt), 64'd1);

    // Soft clear mid-packet with two words buffered
    do_reset();
    pop_period = 1;
    load(1'b0, 32'h7700_0000, 1);
    drive_req();
    run_until_done(1, 50);
    check("sclr_pre_cnt0", 64'(done_cnt0), 64'd1);
    pop_en = 1'b0;
    load(1'b0, 32'h8800_0000, 5);
    drive_req();
    for (int k = 0; k < 20 && q0.size() > 3; k++) tick();
    check("sclr_buffered", 64'(q0.size()), 64'd3);
    check("sclr_head", 64'(phy_din), 64'h8800_0000);
    check("sclr_full_ready", 64'(req0_ready), 64'd0);
    reg_rst = 1'b1;
    tick();
    reg_rst = 1'b0;
    check("sclr_empty", 64'(phy_empty), 64'd1);
    check("sclr_din", 64'(phy_din), 64'd0);
    check("sclr_cnt0", 64'(done_cnt0), 64'd0);
    check("sclr_idle_ready", 64'(req0_ready), 64'd0);

    // Granted requester stalls after its first word is popped
    do_reset();
    pop_period = 1;
    load(1'b0, 32'h9900_0000, 1);
    q0[0].last = 1'b0;
    drive_req();
    for (int k = 0; k < 20 && pop_log.size() < 1; k++) tick();
    check("stall_first_pop", 64'(pop_log.size()), 64'd1);
`ifdef I2C_TX_SCHED_TIMEOUT_EN
    for (int k = 0; k < 40 && abort_cnt < 1; k++) tick();
    check("tmo_abort", 64'(abort_cnt), 64'd1);
    if (pop_cyc.size() == 1)
      check("tmo_abort_delay", 64'(abort_cyc - pop_cyc[0]), 64'(TIMEOUT + 1));
    load(1'b0, 32'h9900_0001, 1);
    drive_req();
    repeat (6) tick();
    check("tmo_flush_acked", 64'(q0.size()), 64'd0);
    check("tmo_flush_npop", 64'(pop_log.size()), 64'd1);
    check("tmo_no_done", 64'(done_log.size()), 64'd0);
`else
    repeat (40) tick();
    check("stall_no_abort", 64'(abort_cnt), 64'd0);
    load(1'b0, 32'h9900_0001, 1);
    drive_req();
    run_until_done(1, 50);
    check("stall_npop", 64'(pop_log.size()), 64'd2);
    check("stall_cnt0", 64'(done_cnt0), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
